// File: rtl/pdm_mic_spi_top.sv
// PDM microphone front end: mic clock generation, 3rd-order CIC decimation
// to 16-bit PCM, SPI slave readout of the latest sample and an LED level display.
// Optional macro LED_METER_EN: LEDs show a thermometer bar of |pcm_out|
// instead of the raw upper PCM byte.
module pdm_mic_spi_top #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DECIM   = 64,
  parameter bit          LR_SEL  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        M_DATA,
  output logic        M_CLK,
  output logic        M_LRSEL,
  input  logic        cs,
  input  logic        sck,
  input  logic        mosi,
  output logic        miso,
  output logic        LED0,
  output logic        LED1,
  output logic        LED2,
  output logic        LED3,
  output logic        LED4,
  output logic        LED5,
  output logic        LED6,
  output logic        LED7,
  output logic [15:0] pcm_out,
  output logic        pcm_ready
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned DEC_W = $clog2(DECIM);
  // 3rd-order CIC growth: 3*log2(DECIM) bits plus sign
  localparam int unsigned CIC_W = 3 * DEC_W + 1;
  localparam int unsigned SHIFT = CIC_W - 16;

  // divider and bit capture
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic             m_clk_q, m_clk_d;
  logic             bit_q, bit_d;
  logic             stb_q, stb_d;

  // CIC state
  logic [DEC_W-1:0]        dec_cnt_q, dec_cnt_d;
  logic                    dec_stb_q, dec_stb_d;
  logic signed [CIC_W-1:0] int1_q, int1_d, int2_q, int2_d, int3_q, int3_d;
  logic signed [CIC_W-1:0] dly1_q, dly1_d, dly2_q, dly2_d, dly3_q, dly3_d;
  logic signed [CIC_W-1:0] x_in, comb1, comb2, comb3;
  logic [15:0]             pcm_sat;
  logic [7:0]              led_lvl;

  // outputs
  logic [15:0] pcm_q, pcm_d;
  logic        rdy_q, rdy_d;
  logic [7:0]  led_q, led_d;

  // SPI
  logic [2:0]  cs_s_q, cs_s_d;
  logic [2:0]  sck_s_q, sck_s_d;
  logic [1:0]  mosi_s_q, mosi_s_d;
  logic [15:0] shadow_q, shadow_d;
  logic [4:0]  bcnt_q, bcnt_d;
  logic        miso_q, miso_d;
  logic        cs_act, cs_fall, sck_rise, sck_fall;
  logic        unused_mosi;

  // mic clock divider and PDM bit strobe
  always_comb begin
    div_cnt_d = (div_cnt_q == CNT_W'(CLK_DIV - 1)) ? '0 : div_cnt_q + CNT_W'(1);
    m_clk_d   = (div_cnt_d >= CNT_W'(CLK_DIV / 2));
    stb_d     = (div_cnt_q == CNT_W'(CLK_DIV - 1));
    bit_d     = stb_d ? M_DATA : bit_q;
  end

  // CIC integrators, decimation counter and combs
  always_comb begin
    x_in      = bit_q ? CIC_W'(1) : '1;
    int1_d    = int1_q;
    int2_d    = int2_q;
    int3_d    = int3_q;
    dec_cnt_d = dec_cnt_q;
    if (stb_q) begin
      int1_d    = int1_q + x_in;
      int2_d    = int2_q + int1_d;
      int3_d    = int3_q + int2_d;
      dec_cnt_d = dec_cnt_q + DEC_W'(1);
    end
    dec_stb_d = stb_q && (dec_cnt_q == '1);

    comb1  = int3_q - dly1_q;
    comb2  = comb1 - dly2_q;
    comb3  = comb2 - dly3_q;
    dly1_d = dly1_q;
    dly2_d = dly2_q;
    dly3_d = dly3_q;
    if (dec_stb_q) begin
      dly1_d = int3_q;
      dly2_d = comb1;
      dly3_d = comb2;
    end
  end

  // scale and saturate; full-scale +/- both alias to the most negative code,
  // and only occur when the whole window matches, so the newest bit gives the sign
  always_comb begin
    if (comb3[CIC_W-1] && (comb3[CIC_W-2:0] == '0)) begin
      pcm_sat = bit_q ? 16'h7FFF : 16'h8000;
    end else begin
      pcm_sat = 16'(comb3 >>> SHIFT);
    end
  end

`ifdef LED_METER_EN
  logic [15:0] mag;

  // thermometer bar of |sample|; LED7 marks full scale
  always_comb begin
    led_lvl = '0;
    if (pcm_sat == 16'h8000) begin
      mag = 16'h7FFF;
    end else if (pcm_sat[15]) begin
      mag = 16'(~pcm_sat + 16'd1);
    end else begin
      mag = pcm_sat;
    end
    for (int k = 0; k < 7; k++) begin
      led_lvl[k] = (mag >= (16'd1 << (8 + k)));
    end
    led_lvl[7] = (mag == 16'h7FFF);
  end
`else
  // raw upper PCM byte
  always_comb begin
    led_lvl = pcm_sat[15:8];
  end
`endif

  // PCM output, ready pulse and LED latch
  always_comb begin
    pcm_d = dec_stb_q ? pcm_sat : pcm_q;
    rdy_d = dec_stb_q;
    led_d = dec_stb_q ? led_lvl : led_q;
  end

  // SPI synchronizers, edge detect and shift register
  always_comb begin
    cs_s_d   = {cs_s_q[1:0], cs};
    sck_s_d  = {sck_s_q[1:0], sck};
    mosi_s_d = {mosi_s_q[0], mosi};
    cs_act   = ~cs_s_q[1];
    cs_fall  = cs_s_q[2] & ~cs_s_q[1];
    sck_rise = ~sck_s_q[2] & sck_s_q[1];
    sck_fall = sck_s_q[2] & ~sck_s_q[1];

    shadow_d = shadow_q;
    bcnt_d   = bcnt_q;
    miso_d   = miso_q;
    if (!cs_act) begin
      miso_d = 1'b0;
      bcnt_d = '0;
    end else if (cs_fall) begin
      shadow_d = pcm_d;
      bcnt_d   = '0;
      miso_d   = pcm_d[15];
    end else if (sck_rise) begin
      bcnt_d = bcnt_q + 5'd1;
    end else if (sck_fall) begin
      if (bcnt_q >= 5'd16) begin
        // word done: restart on the newest sample (pcm_d wins a same-cycle update)
        shadow_d = pcm_d;
        bcnt_d   = '0;
        miso_d   = pcm_d[15];
      end else begin
        shadow_d = {shadow_q[14:0], 1'b0};
        miso_d   = shadow_q[14];
      end
    end
  end

  // mosi is synchronized for completeness but carries no command
  assign unused_mosi = mosi_s_q[1];

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      m_clk_q   <= 1'b0;
      bit_q     <= 1'b0;
      stb_q     <= 1'b0;
      dec_cnt_q <= '0;
      dec_stb_q <= 1'b0;
      int1_q    <= '0;
      int2_q    <= '0;
      int3_q    <= '0;
      dly1_q    <= '0;
      dly2_q    <= '0;
      dly3_q    <= '0;
      pcm_q     <= '0;
      rdy_q     <= 1'b0;
      led_q     <= '0;
      cs_s_q    <= '0;
      sck_s_q   <= '0;
      mosi_s_q  <= '0;
      shadow_q  <= '0;
      bcnt_q    <= '0;
      miso_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      m_clk_q   <= m_clk_d;
      bit_q     <= bit_d;
      stb_q     <= stb_d;
      dec_cnt_q <= dec_cnt_d;
      dec_stb_q <= dec_stb_d;
      int1_q    <= int1_d;
      int2_q    <= int2_d;
      int3_q    <= int3_d;
      dly1_q    <= dly1_d;
      dly2_q    <= dly2_d;
      dly3_q    <= dly3_d;
      pcm_q     <= pcm_d;
      rdy_q     <= rdy_d;
      led_q     <= led_d;
      cs_s_q    <= cs_s_d;
      sck_s_q   <= sck_s_d;
      mosi_s_q  <= mosi_s_d;
      shadow_q  <= shadow_d;
      bcnt_q    <= bcnt_d;
      miso_q    <= miso_d;
    end
  end

  assign M_CLK     = m_clk_q;
  assign M_LRSEL   = LR_SEL;
  assign miso      = miso_q;
  assign pcm_out   = pcm_q;
  assign pcm_ready = rdy_q;
  assign {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0} = led_q;

endmodule

// File: tb/tb_pdm_mic_spi_top.sv
// Directed bench for pdm_mic_spi_top: table of steady PDM patterns with
// expected settled PCM/LED values, plus reset, clock and SPI sequences.
module tb_pdm_mic_spi_top;

  localparam int SCK_HALF = 2500;   // 200 kHz SCK against a 40-unit clk

  logic        clk = 1'b0;
  logic        rst;
  logic        M_DATA;
  logic        M_CLK, M_LRSEL;
  logic        cs, sck, mosi, miso;
  logic        LED0, LED1, LED2, LED3, LED4, LED5, LED6, LED7;
  logic [15:0] pcm_out;
  logic        pcm_ready;
  logic [7:0]  leds;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pat   = 0;
  int bit_idx;

  pdm_mic_spi_top dut (
    .clk(clk), .rst(rst), .M_DATA(M_DATA), .M_CLK(M_CLK), .M_LRSEL(M_LRSEL),
    .cs(cs), .sck(sck), .mosi(mosi), .miso(miso),
    .LED0(LED0), .LED1(LED1), .LED2(LED2), .LED3(LED3),
    .LED4(LED4), .LED5(LED5), .LED6(LED6), .LED7(LED7),
    .pcm_out(pcm_out), .pcm_ready(pcm_ready)
  );

  assign leds = {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0};

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // PDM pattern generator: bit i of pattern p
  function automatic logic pat_bit(input int p, input int i);
    logic [7:0] b;
    int         bi;
    case (p)
      0: return 1'b1;
      1: return 1'b0;
      2: return (i % 2 == 0);
      default: begin
        bi = i / 8;
        b  = (bi <= 10) ? 8'(bi) : 8'h00;
        return b[7 - (i % 8)];
      end
    endcase
  endfunction

  // new mic bit after every falling M_CLK; restart pattern on reset
  always @(negedge M_CLK or posedge rst) begin
    if (rst) begin
      bit_idx = 0;
      M_DATA  = pat_bit(pat, 0);
    end else begin
      bit_idx = bit_idx + 1;
      M_DATA  = pat_bit(pat, bit_idx);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (pcm_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s: no pcm_ready within 400 clks", tag);
    end
  endtask

  task automatic do_reset(input int p);
    @(negedge clk);
    pat = p;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // SPI master, mode 0: capture miso just before each rising sck
  task automatic spi_xfer(input int nbits, output logic [31:0] word);
    word = '0;
    cs   = 1'b0;
    #(SCK_HALF);
    for (int i = 0; i < nbits; i++) begin
      word = {word[30:0], miso};
      mosi = ~mosi;
      sck  = 1'b1;
      #(SCK_HALF);
      sck  = 1'b0;
      #(SCK_HALF);
    end
    cs = 1'b1;
    #(SCK_HALF);
  endtask

  typedef struct {
    int          p;
    logic [15:0] pcm;
    logic [7:0]  led;
  } vec_t;

  vec_t        vecs[3];
  bit          ok;
  int          t[6];
  logic [31:0] w;
  logic [5:0]  mexp;

  initial begin
    cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    pat = 0;
    rst = 1'b1;

    vecs[0] = '{p: 2, pcm: 16'h0000, led: 8'h00};
`ifdef LED_METER_EN
    vecs[1] = '{p: 1, pcm: 16'h8000, led: 8'hFF};
    vecs[2] = '{p: 0, pcm: 16'h7FFF, led: 8'hFF};
`else
    vecs[1] = '{p: 1, pcm: 16'h8000, led: 8'h80};
    vecs[2] = '{p: 0, pcm: 16'h7FFF, led: 8'h7F};
`endif

    repeat (3) @(negedge clk);
    #1;
    chk("rst_pcm", 32'(pcm_out), 32'h0);
    chk("rst_ready", 32'(pcm_ready), 32'h0);
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_miso", 32'(miso), 32'h0);
    chk("rst_mclk", 32'(M_CLK), 32'h0);
    chk("lrsel", 32'(M_LRSEL), 32'h0);

    // steady patterns: 4 samples, check settled 3rd/4th, period and pulse width
    for (int v = 0; v < 3; v++) begin
      do_reset(vecs[v].p);
      for (int k = 1; k <= 4; k++) begin
        wait_ready($sformatf("v%0d_ready%0d", v, k), ok);
        t[k] = cyc;
        if (ok && k >= 3) begin
          chk($sformatf("v%0d_pcm%0d", v, k), 32'(pcm_out), 32'(vecs[v].pcm));
          chk($sformatf("v%0d_led%0d", v, k), 32'(leds), 32'(vecs[v].led));
          chk($sformatf("v%0d_period%0d", v, k), 32'(t[k] - t[k-1]), 32'd256);
        end
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_width%0d", v, k), 32'(pcm_ready), 32'h0);
      end
    end

    // SPI readout while pcm_out sits at 0x7FFF
    spi_xfer(16, w);
    chk("spi16", w, 32'h0000_7FFF);
    spi_xfer(32, w);
    chk("spi32", w, 32'h7FFF_7FFF);
    spi_xfer(5, w);
    chk("spi_abort_bits", w, 32'h0000_000F);
    repeat (10) @(posedge clk);
    #1;
    chk("miso_idle", 32'(miso), 32'h0);
    spi_xfer(16, w);
    chk("spi_after_abort", w, 32'h0000_7FFF);

    // reset mid-stream, then mic clock phase after release
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_pcm", 32'(pcm_out), 32'h0);
    chk("midrst_leds", 32'(leds), 32'h0);
    chk("midrst_mclk", 32'(M_CLK), 32'h0);
    chk("midrst_ready", 32'(pcm_ready), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mexp = 6'b100110;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("mclk_edge%0d", k + 1), 32'(M_CLK), 32'(mexp[k]));
    end
    chk("postrst_pcm", 32'(pcm_out), 32'h0);
    chk("postrst_miso", 32'(miso), 32'h0);

    // byte stream 0x00..0x0A then silence: negative, then fully saturated
    do_reset(3);
    for (int k = 1; k <= 5; k++) begin
      wait_ready($sformatf("bytes_ready%0d", k), ok);
      if (ok && k == 3) begin
        chk("bytes_noX", 32'($isunknown({pcm_out, leds, miso, M_CLK, M_LRSEL})), 32'h0);
        chk("bytes_neg", 32'(pcm_out[15]), 32'h1);
      end
      if (ok && k == 5) chk("bytes_sat", 32'(pcm_out), 32'h8000);
    end

    // SPI readout of a negative full-scale sample
    do_reset(1);
    for (int k = 1; k <= 3; k++) wait_ready($sformatf("zero_ready%0d", k), ok);
    spi_xfer(16, w);
    chk("spi_neg", w, 32'h0000_8000);
    chk("lrsel_end", 32'(M_LRSEL), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
